// File: rtl/load_select_sequencer.sv
// ---------------------------------------------------------------------------
// load_select_sequencer
//
// Control-side driver of the LOAD_SELECT register-load interface of the
// 19-bit CPU. It sequences fetch / decode / execute / writeback, owns the
// program counter and instruction register, and emits one load strobe at a
// time (LOAD_PC, LOAD_IR, LOAD_REG_A/B/C) together with the data to load.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        leave IDLE and begin fetching (ignored elsewhere)
//   mem_req      instruction read request, held until mem_rvalid
//   mem_addr     read address (always equals pc)
//   mem_rdata    instruction word, qualified by mem_rvalid
//   mem_rvalid   read data valid, only honoured in FETCH
//   alu_start    one-cycle ALU launch pulse (first EXEC cycle)
//   alu_op       opcode presented to the ALU (ir[18:14])
//   alu_done     ALU result valid, only honoured in EXEC
//   alu_result   ALU result
//   load_en      load strobe
//   load_select  load target: 000 PC, 001 IR, 010 REG_A, 011 REG_B, 100 REG_C
//   load_data    data for the target, 19-bit values zero-extended
//   pc           current program counter
//   ir           current instruction register
//   halted       high while in HALT
//
// Instruction fields: opcode = ir[18:14], rd = ir[13:12],
// jump target = {6'b0, ir[13:0]}.
// ---------------------------------------------------------------------------
module load_select_sequencer #(
  parameter logic [19:0] PC_RESET    = 20'h00000,
  parameter logic [4:0]  NOP_OPCODE  = 5'h00,
  parameter logic [4:0]  JMP_OPCODE  = 5'h10,
  parameter logic [4:0]  HALT_OPCODE = 5'h1F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic [18:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        alu_start,
  output logic [4:0]  alu_op,
  input  logic        alu_done,
  input  logic [18:0] alu_result,
  output logic        load_en,
  output logic [2:0]  load_select,
  output logic [19:0] load_data,
  output logic [19:0] pc,
  output logic [18:0] ir,
  output logic        halted
);

  // Load targets on the LOAD_SELECT bus.
  localparam logic [2:0] SEL_PC    = 3'b000;
  localparam logic [2:0] SEL_IR    = 3'b001;
  localparam logic [2:0] SEL_REG_A = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_EXEC,
    S_WRITEBACK,
    S_PC_INC,
    S_JUMP,
    S_HALT
  } state_t;

  state_t      state_q,       state_d;
  logic [19:0] pc_q,          pc_d;
  logic [18:0] ir_q,          ir_d;
  logic        mem_req_q,     mem_req_d;
  logic        alu_start_q,   alu_start_d;
  logic        load_en_q,     load_en_d;
  logic [2:0]  load_select_q, load_select_d;
  logic [19:0] load_data_q,   load_data_d;
  logic        halted_q,      halted_d;

  // Decoded fields of the current instruction.
  logic [4:0]  opcode;
  logic [1:0]  rd;
  logic [19:0] jump_target;
  logic [19:0] pc_plus_one;

  assign opcode      = ir_q[18:14];
  assign rd          = ir_q[13:12];
  assign jump_target = {6'b0, ir_q[13:0]};
  assign pc_plus_one = pc_q + 20'd1;   // natural wrap FFFFF -> 00000

  // -------------------------------------------------------------------------
  // Next-state / output logic.
  //
  // Every output is a flop. The strobe for a state is therefore computed on
  // the transition *into* that state, so that load_en/load_select/load_data
  // are valid during exactly the cycle the FSM spends in LOAD_IR, WRITEBACK,
  // PC_INC or JUMP. Architectural state (ir, pc) is committed from the
  // strobe register at the end of that cycle, which keeps the committed
  // value identical to what was put on the bus.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_start_d   = 1'b0;
    load_en_d     = 1'b0;
    load_select_d = 3'b000;
    load_data_d   = 20'h00000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // A response arriving in the very first FETCH cycle is accepted,
        // since mem_req is already high for that whole cycle.
        if (mem_rvalid) begin
          state_d       = S_LOAD_IR;
          load_en_d     = 1'b1;
          load_select_d = SEL_IR;
          load_data_d   = {1'b0, mem_rdata};
        end
      end

      S_LOAD_IR: begin
        // The captured word is still sitting in the strobe register.
        ir_d    = load_data_q[18:0];
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (opcode == HALT_OPCODE) begin
          state_d = S_HALT;
        end else if (opcode == NOP_OPCODE) begin
          state_d       = S_PC_INC;
          load_en_d     = 1'b1;
          load_select_d = SEL_PC;
          load_data_d   = pc_plus_one;
        end else if (opcode == JMP_OPCODE) begin
          state_d       = S_JUMP;
          load_en_d     = 1'b1;
          load_select_d = SEL_PC;
          load_data_d   = jump_target;
        end else begin
          // alu_start is only raised on this transition, so it is a single
          // pulse in the first EXEC cycle however long the ALU takes.
          state_d     = S_EXEC;
          alu_start_d = 1'b1;
        end
      end

      S_EXEC: begin
        if (alu_done) begin
          if (rd == 2'b11) begin
            // rd=11 discards the result: go straight to the PC update.
            state_d       = S_PC_INC;
            load_en_d     = 1'b1;
            load_select_d = SEL_PC;
            load_data_d   = pc_plus_one;
          end else begin
            // rd 00/01/10 map onto REG_A/REG_B/REG_C (010/011/100).
            state_d       = S_WRITEBACK;
            load_en_d     = 1'b1;
            load_select_d = SEL_REG_A + {1'b0, rd};
            load_data_d   = {1'b0, alu_result};
          end
        end
      end

      S_WRITEBACK: begin
        state_d       = S_PC_INC;
        load_en_d     = 1'b1;
        load_select_d = SEL_PC;
        load_data_d   = pc_plus_one;
      end

      S_PC_INC, S_JUMP: begin
        pc_d    = load_data_q;
        state_d = S_FETCH;
      end

      S_HALT: begin
        // Only reset leaves HALT.
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_req_d = (state_d == S_FETCH);
    halted_d  = (state_d == S_HALT);
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RESET;
      ir_q          <= 19'h00000;
      mem_req_q     <= 1'b0;
      alu_start_q   <= 1'b0;
      load_en_q     <= 1'b0;
      load_select_q <= 3'b000;
      load_data_q   <= 20'h00000;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      mem_req_q     <= mem_req_d;
      alu_start_q   <= alu_start_d;
      load_en_q     <= load_en_d;
      load_select_q <= load_select_d;
      load_data_q   <= load_data_d;
      halted_q      <= halted_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign alu_start   = alu_start_q;
  assign alu_op      = ir_q[18:14];
  assign load_en     = load_en_q;
  assign load_select = load_select_q;
  assign load_data   = load_data_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_load_select_sequencer.sv
// ---------------------------------------------------------------------------
// tb_load_select_sequencer
//
// Two instances share the same stimulus: dut uses the default PC_RESET and
// dut_wrap starts at 20'hFFFFF, so the first NOP exercises pc wrap-around.
// A table of instructions drives a small memory/ALU responder; expected load
// strobes are pushed to a queue when each instruction word is returned and
// a monitor pops/compares them as the DUT emits load_en.
// ---------------------------------------------------------------------------
module tb_load_select_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [18:0] mem_rdata;
  logic        mem_rvalid;
  logic        alu_done;
  logic [18:0] alu_result;

  logic        mem_req,   w_mem_req;
  logic [19:0] mem_addr,  w_mem_addr;
  logic        alu_start, w_alu_start;
  logic [4:0]  alu_op,    w_alu_op;
  logic        load_en,   w_load_en;
  logic [2:0]  load_select, w_load_select;
  logic [19:0] load_data, w_load_data;
  logic [19:0] pc,        w_pc;
  logic [18:0] ir,        w_ir;
  logic        halted,    w_halted;

  always #5 clk = ~clk;

  load_select_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .alu_start(alu_start), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .load_en(load_en),
    .load_select(load_select), .load_data(load_data), .pc(pc), .ir(ir),
    .halted(halted)
  );

  load_select_sequencer #(.PC_RESET(20'hFFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .alu_start(w_alu_start), .alu_op(w_alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .load_en(w_load_en),
    .load_select(w_load_select), .load_data(w_load_data), .pc(w_pc),
    .ir(w_ir), .halted(w_halted)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [19:0] data;
  } strobe_t;

  typedef struct {
    logic [18:0] instr;
    int          mem_lat;
    int          alu_lat;
    logic [18:0] alu_res;
    bit          spur;        // wiggle start/alu_done while fetching
    bit          exp_alu;
    bit          exp_wb;
    logic [2:0]  exp_wb_sel;
    bit          is_halt;
    logic [19:0] exp_pc_next;
    int          exp_gap;     // cycles from rvalid to next mem_req, 0 = skip
  } vec_t;

  strobe_t exp_q[$];
  strobe_t cur_exp;
  vec_t    vecs[8];

  int tests = 0;
  int fails = 0;
  int alu_start_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobe monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_start) alu_start_cnt++;
      if (load_en) begin
        $display("[TB] strobe sel=%b data=%h", load_select, load_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got sel=%b data=%h, expected no strobe",
                   load_select, load_data);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("strobe_sel", {29'b0, load_select}, {29'b0, cur_exp.sel});
          chk("strobe_data", {12'b0, load_data}, {12'b0, cur_exp.data});
        end
      end else begin
        chk("idle_bus_zero", {9'b0, load_select, load_data}, 32'h0);
      end
    end
  end

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL mem_req_timeout: got no request, expected one within 50 cycles");
    end
  endtask

  // Called at a negedge with mem_req high (FETCH). Returns the word, runs
  // the ALU if needed, then waits for the next fetch and checks the result.
  task automatic run_instr(input vec_t v, input logic [19:0] cur_pc);
    bit ok;
    int starts0;
    int t_issue;
    strobe_t s;

    chk("mem_addr", {12'b0, mem_addr}, {12'b0, cur_pc});
    for (int i = 0; i < v.mem_lat; i++) begin
      if (v.spur) begin
        start    = 1'b1;
        alu_done = 1'b1;
      end
      @(negedge clk);
      chk("mem_req_held", {31'b0, mem_req}, 32'd1);
    end
    start    = 1'b0;
    alu_done = 1'b0;

    starts0    = alu_start_cnt;
    t_issue    = cyc;
    mem_rvalid = 1'b1;
    mem_rdata  = v.instr;
    s.sel = 3'b001; s.data = {1'b0, v.instr};
    exp_q.push_back(s);
    if (v.exp_wb) begin
      s.sel = v.exp_wb_sel; s.data = {1'b0, v.alu_res};
      exp_q.push_back(s);
    end
    if (!v.is_halt) begin
      s.sel = 3'b000; s.data = v.exp_pc_next;
      exp_q.push_back(s);
    end
    $display("[TB] issue instr=%h pc=%h", v.instr, cur_pc);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 19'h55555;   // garbage: the DUT must use the captured word

    if (v.exp_alu) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (alu_start) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("alu_start_seen", {31'b0, ok}, 32'd1);
      chk("alu_op", {27'b0, alu_op}, {27'b0, v.instr[18:14]});
      repeat (v.alu_lat) @(negedge clk);
      alu_done   = 1'b1;
      alu_result = v.alu_res;
      @(negedge clk);
      alu_done   = 1'b0;
      alu_result = 19'($urandom);
    end

    if (v.is_halt) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (halted) begin
          ok = 1'b1;
          break;
        end
      end
      chk("halted", {31'b0, halted}, 32'd1);
      chk("halt_no_req", {31'b0, mem_req}, 32'd0);
    end else begin
      wait_mem_req(ok);
      if (ok && v.exp_gap != 0) chk("fetch_gap", cyc - t_issue, v.exp_gap);
      chk("pc_next", {12'b0, pc}, {12'b0, v.exp_pc_next});
      chk("ir", {13'b0, ir}, {13'b0, v.instr});
    end
    chk("alu_start_pulses", alu_start_cnt - starts0, v.exp_alu ? 32'd1 : 32'd0);
    chk("strobes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [19:0] cur_pc;

    //             instr       mlat alat res         spur alu wb  sel     halt next_pc     gap
    vecs[0] = '{19'h00000, 2, 0, 19'h00000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 20'h00001, 4};
    vecs[1] = '{19'h0D000, 1, 3, 19'h7ABCD, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 20'h00002, 0};
    vecs[2] = '{19'h0F000, 0, 0, 19'h12345, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 20'h00003, 0};
    vecs[3] = '{19'h14000, 1, 1, 19'h00001, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 20'h00004, 0};
    vecs[4] = '{19'h1E000, 3, 2, 19'h7FFFF, 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, 20'h00005, 0};
    vecs[5] = '{19'h43FFF, 0, 0, 19'h00000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 20'h03FFF, 4};
    vecs[6] = '{19'h00000, 0, 0, 19'h00000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 20'h04000, 4};
    vecs[7] = '{19'h7C000, 1, 0, 19'h00000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 20'h04000, 0};

    rst_n = 1'b0; start = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    alu_done = 1'b0; alu_result = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", {12'b0, mem_addr}, 32'd0);
    chk("rst_alu_start", {31'b0, alu_start}, 32'd0);
    chk("rst_load_en", {31'b0, load_en}, 32'd0);
    chk("rst_bus", {9'b0, load_select, load_data}, 32'd0);
    chk("rst_ir", {13'b0, ir}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_wrap_pc", {12'b0, w_pc}, 32'h000FFFFF);

    // Idle without start.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_req", {31'b0, mem_req}, 32'd0);
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mem_req(ok);

    cur_pc = 20'h00000;
    for (int k = 0; k < 8; k++) begin
      run_instr(vecs[k], cur_pc);
      cur_pc = vecs[k].exp_pc_next;
      if (k == 0) chk("wrap_pc_zero", {12'b0, w_pc}, 32'd0);
      if (k == 5) chk("wrap_jump_pc", {12'b0, w_pc}, 32'h00003FFF);
    end

    // HALT is sticky: start, rvalid and alu_done must all be ignored.
    for (int i = 0; i < 10; i++) begin
      start      = i[0];
      mem_rvalid = ~i[0];
      alu_done   = 1'b1;
      mem_rdata  = 19'h00000;
      @(negedge clk);
      chk("halt_req_off", {31'b0, mem_req}, 32'd0);
      chk("halt_stays", {31'b0, halted}, 32'd1);
    end
    start = 1'b0; mem_rvalid = 1'b0; alu_done = 1'b0;

    // Reset out of HALT, then reset in the middle of a fetch.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("halt_cleared", {31'b0, halted}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mem_req(ok);
    #2 rst_n = 1'b0;
    #1;
    chk("midfetch_req_dropped", {31'b0, mem_req}, 32'd0);
    chk("midfetch_pc", {12'b0, pc}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 19'h0C123;
    alu_done   = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    alu_done   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {31'b0, mem_req}, 32'd0);
      chk("post_reset_ir", {13'b0, ir}, 32'd0);
    end

    // Still alive afterwards.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mem_req(ok);
    if (ok) run_instr(vecs[0], 20'h00000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
